// File: rtl/alphamission_video_pkg.sv
// Shared definitions for the Alpha Mission video-board bus logic.
package alphamission_video_pkg;

  typedef enum logic [2:0] {
    IDLE,
    REG,
    WAIT_SLOT,
    ACC_SETUP,
    ACC_STROBE,
    ACC_CAPT,
    ACK
  } back1_bus_state_t;

  localparam logic [1:0] B1_REG_SCRY = 2'd0;
  localparam logic [1:0] B1_REG_SCRX = 2'd1;
  localparam logic [1:0] B1_REG_CTRL = 2'd2;

  localparam logic [7:0] B1_BUS_IDLE = 8'hFF;

  function automatic logic [7:0] b1_ctrl_byte(input logic [1:0] bank,
                                              input logic       x8,
                                              input logic       y8);
    return {4'h0, bank, x8, y8};
  endfunction

endpackage

// File: rtl/back1_cpu_bus_master.sv
// CPU initiator for the Back1 shared video bus: scroll/control registers and slot-gated VRAM access.
// Build option BACK1_BUS_READ_EN enables VRAM reads and control-register readback.
module back1_cpu_bus_master
  import alphamission_video_pkg::*;
#(
  parameter int VRAM_AW  = 12,
  parameter int SLOT_MIN = 3
) (
  input  logic               clk,
  input  logic               RESET,
  input  logic               cpu_req,
  input  logic               cpu_wr,
  input  logic [12:0]        cpu_addr,
  input  logic [7:0]         cpu_din,
  output logic [7:0]         cpu_dout,
  output logic               cpu_ack,
  input  logic               V_C,
  input  logic [7:0]         VD_in,
  output logic [7:0]         VD_out,
  output logic [VRAM_AW-1:0] VA,
  output logic               BACK1_VRAM_CSn,
  output logic               VRD,
  output logic               VWE,
  output logic               VOE,
  output logic               VDG,
  output logic               B1SY,
  output logic               B1SX,
  output logic               B1Y8,
  output logic               B1X8,
  output logic [1:0]         B1_TILEBANK
);

`ifdef BACK1_BUS_READ_EN
  localparam bit READ_EN = 1'b1;
`else
  localparam bit READ_EN = 1'b0;
`endif

  // Setup, strobe and capture each need one V_C-high cycle.
  if (SLOT_MIN < 3) begin : g_slot_check
    $error("SLOT_MIN too small for setup/strobe/capture");
  end
  if (VRAM_AW > 12) begin : g_aw_check
    $error("VRAM_AW exceeds the CPU VRAM window");
  end

  back1_bus_state_t state_q;
  logic [11:0]      addr_q;
  logic [7:0]       data_q;
  logic             wr_q;

  logic [11:0]      rq_addr_d;
  logic [7:0]       rq_data_d;
  logic             rq_wr_d;
  logic             go_setup;
  logic             release_bus;

  // In IDLE the request is taken straight from the CPU pins so an access can start on the sampling edge.
  always_comb begin
    rq_addr_d = addr_q;
    rq_data_d = data_q;
    rq_wr_d   = wr_q;
    if (state_q == IDLE) begin
      rq_addr_d = cpu_addr[11:0];
      rq_data_d = cpu_din;
      rq_wr_d   = cpu_wr;
    end
  end

  assign go_setup = V_C && ((state_q == WAIT_SLOT) ||
                            ((state_q == IDLE) && cpu_req && !cpu_addr[12] &&
                             (cpu_wr || READ_EN)));

  // Leaving the strobe phase, normally or because the slot was withdrawn.
  assign release_bus = ((state_q == ACC_SETUP) && !V_C) || (state_q == ACC_STROBE);

  always_ff @(posedge clk) begin
    if (RESET) begin
      state_q        <= IDLE;
      addr_q         <= '0;
      data_q         <= B1_BUS_IDLE;
      wr_q           <= 1'b0;
      cpu_ack        <= 1'b0;
      cpu_dout       <= B1_BUS_IDLE;
      VD_out         <= B1_BUS_IDLE;
      VA             <= '0;
      BACK1_VRAM_CSn <= 1'b1;
      VRD            <= 1'b0;
      VWE            <= 1'b1;
      VOE            <= 1'b1;
      VDG            <= 1'b1;
      B1SY           <= 1'b0;
      B1SX           <= 1'b0;
      B1Y8           <= 1'b0;
      B1X8           <= 1'b0;
      B1_TILEBANK    <= 2'b00;
    end else begin
      cpu_ack <= 1'b0;
      B1SY    <= 1'b0;
      B1SX    <= 1'b0;

      case (state_q)
        IDLE: begin
          if (cpu_req) begin
            addr_q <= cpu_addr[11:0];
            data_q <= cpu_din;
            wr_q   <= cpu_wr;
            if (!cpu_wr && !READ_EN) begin
              state_q  <= ACK;
              cpu_ack  <= 1'b1;
              cpu_dout <= B1_BUS_IDLE;
            end else if (cpu_addr[12]) begin
              state_q <= REG;
              if (cpu_wr) begin
                case (cpu_addr[1:0])
                  B1_REG_SCRY: begin
                    VD_out <= cpu_din;
                    B1SY   <= 1'b1;
                  end
                  B1_REG_SCRX: begin
                    VD_out <= cpu_din;
                    B1SX   <= 1'b1;
                  end
                  B1_REG_CTRL: begin
                    B1Y8        <= cpu_din[0];
                    B1X8        <= cpu_din[1];
                    B1_TILEBANK <= cpu_din[3:2];
                  end
                  default: ;
                endcase
              end
            end else begin
              state_q <= WAIT_SLOT;
            end
          end
        end
        REG: begin
          state_q <= ACK;
          cpu_ack <= 1'b1;
          VD_out  <= B1_BUS_IDLE;
          if (!wr_q) begin
            cpu_dout <= (addr_q[1:0] == B1_REG_CTRL) ?
                        b1_ctrl_byte(B1_TILEBANK, B1X8, B1Y8) : B1_BUS_IDLE;
          end
        end
        WAIT_SLOT: ;
        ACC_SETUP: begin
          if (!V_C) begin
            state_q <= WAIT_SLOT;
          end else begin
            state_q <= ACC_STROBE;
            VWE     <= !wr_q;
          end
        end
        ACC_STROBE: begin
          if (!V_C) begin
            state_q <= WAIT_SLOT;
          end else begin
            state_q <= ACC_CAPT;
            if (!wr_q) cpu_dout <= VD_in;
          end
        end
        ACC_CAPT: begin
          state_q <= ACK;
          cpu_ack <= 1'b1;
        end
        ACK:     state_q <= IDLE;
        default: state_q <= IDLE;
      endcase

      if (release_bus) begin
        BACK1_VRAM_CSn <= 1'b1;
        VRD            <= 1'b0;
        VWE            <= 1'b1;
        VOE            <= 1'b1;
        VDG            <= 1'b1;
        VD_out         <= B1_BUS_IDLE;
      end

      if (go_setup) begin
        state_q        <= ACC_SETUP;
        VA             <= rq_addr_d[VRAM_AW-1:0];
        BACK1_VRAM_CSn <= 1'b0;
        VDG            <= 1'b0;
        VRD            <= rq_wr_d;
        VOE            <= rq_wr_d;
        VD_out         <= rq_wr_d ? rq_data_d : B1_BUS_IDLE;
      end
    end
  end

endmodule
